// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: the queued prediction record and the recovery FSM states.
package bru_pkg;

    localparam int BRU_ADDR_WIDTH = 26;

    typedef struct packed {
        logic [BRU_ADDR_WIDTH-1:0] pc;
        logic                      pred_taken;
        logic [BRU_ADDR_WIDTH-1:0] pred_target;
    } bru_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/decode/predictor-facing signal bundle of the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int CNT_WIDTH  = 32
);
    logic                  f_valid;
    logic                  f_ready;
    logic [ADDR_WIDTH-1:0] f_pc;
    logic                  f_pred_taken;
    logic [ADDR_WIDTH-1:0] f_pred_target;
    logic                  r_valid;
    logic                  r_taken;
    logic [ADDR_WIDTH-1:0] r_target;
    logic                  bp_we;
    logic                  bp_taken;
    logic [ADDR_WIDTH-1:0] bp_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  err_underflow;
    logic [CNT_WIDTH-1:0]  stat_branches;
    logic [CNT_WIDTH-1:0]  stat_mispredicts;

    // The environment (fetch, decode, predictor) is the master side.
    modport master (
        output f_valid, f_pc, f_pred_taken, f_pred_target,
        output r_valid, r_taken, r_target,
        input  f_ready, bp_we, bp_taken, bp_pc, redirect_valid, redirect_pc,
        input  err_underflow, stat_branches, stat_mispredicts
    );

    modport slave (
        input  f_valid, f_pc, f_pred_taken, f_pred_target,
        input  r_valid, r_taken, r_target,
        output f_ready, bp_we, bp_taken, bp_pc, redirect_valid, redirect_pc,
        output err_underflow, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/bru_fifo.sv
// In-order circular queue of outstanding predictions; flush beats push and pop.
module bru_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  bru_entry_t din,
    output bru_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);

    bru_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Checks queued fetch predictions against decode outcomes; trains the predictor and redirects fetch.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int ADDR_WIDTH     = BRU_ADDR_WIDTH,
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

    bru_state_e            state;
    logic [RC_W-1:0]       rec_cnt;
    bru_entry_t            head;
    bru_entry_t            din;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  resolve;
    logic                  mispredict;
    logic                  underflow;

    logic                  bp_we_q;
    logic                  bp_taken_q;
    logic [ADDR_WIDTH-1:0] bp_pc_q;
    logic                  redirect_valid_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  branches_q;
    logic [CNT_WIDTH-1:0]  mispredicts_q;

    assign bus.f_ready = !full && (state == RUN);
    assign push        = bus.f_valid && bus.f_ready;
    assign resolve     = (state == RUN) && bus.r_valid && !empty;
    assign underflow   = (state == RUN) && bus.r_valid && empty;
    assign mispredict  = resolve && ((head.pred_taken != bus.r_taken) ||
                                     (bus.r_taken && (head.pred_target != bus.r_target)));

    assign din.pc          = bus.f_pc;
    assign din.pred_taken  = bus.f_pred_taken;
    assign din.pred_target = bus.f_pred_target;

    // A mispredict flushes the whole queue, which also discards any same-cycle push.
    bru_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (resolve),
        .flush (mispredict),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RUN;
            rec_cnt          <= '0;
            bp_we_q          <= 1'b0;
            bp_taken_q       <= 1'b0;
            bp_pc_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            err_q            <= 1'b0;
            branches_q       <= '0;
            mispredicts_q    <= '0;
        end else begin
            bp_we_q          <= resolve;
            redirect_valid_q <= mispredict;
            if (resolve) begin
                bp_taken_q <= bus.r_taken;
                bp_pc_q    <= head.pc;
                if (branches_q != '1) branches_q <= branches_q + CNT_WIDTH'(1);
            end
            if (mispredict) begin
                redirect_pc_q <= bus.r_taken ? bus.r_target : head.pc + ADDR_WIDTH'(1);
                if (mispredicts_q != '1) mispredicts_q <= mispredicts_q + CNT_WIDTH'(1);
            end
            if (underflow) err_q <= 1'b1;

            // Fetch stays held off for exactly RECOVER_CYCLES cycles after a redirect.
            case (state)
                RUN: begin
                    if (mispredict) begin
                        state   <= RECOVER;
                        rec_cnt <= RC_W'(RECOVER_CYCLES - 1);
                    end
                end
                RECOVER: begin
                    if (rec_cnt == '0) state <= RUN;
                    else               rec_cnt <= rec_cnt - RC_W'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.bp_we            = bp_we_q;
    assign bus.bp_taken         = bp_taken_q;
    assign bus.bp_pc            = bp_pc_q;
    assign bus.redirect_valid   = redirect_valid_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.err_underflow    = err_q;
    assign bus.stat_branches    = branches_q;
    assign bus.stat_mispredicts = mispredicts_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven and scoreboard-checked bench for branch_resolve_unit (4-bit stats to reach saturation).
module tb_branch_resolve_unit;
    import bru_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.ADDR_WIDTH(26), .CNT_WIDTH(4)) bus ();

    branch_resolve_unit #(
        .ADDR_WIDTH     (26),
        .DEPTH          (4),
        .RECOVER_CYCLES (2),
        .CNT_WIDTH      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [25:0] pc;
        logic        pt;
        logic [25:0] ptgt;
        logic        rt;
        logic [25:0] rtgt;
        logic        mis;
        logic [25:0] rpc;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [25:0] pc;
        logic        mis;
        logic [25:0] rpc;
    } sb_t;

    vec_t        vecs [7];
    sb_t         sb_q [$];
    sb_t         mon_exp;
    logic [25:0] model_q [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Push one prediction, resolve it next cycle, then wait out any recovery window.
    task automatic applyStimulus(input logic [25:0] pc, input logic pt, input logic [25:0] ptgt,
                                 input logic rt, input logic [25:0] rtgt,
                                 input logic mis, input logic [25:0] rpc);
        int n;
        checkOutput("push_ready", bus.f_ready, 1);
        bus.f_valid = 1'b1; bus.f_pc = pc; bus.f_pred_taken = pt; bus.f_pred_target = ptgt;
        stepCycle();
        bus.f_valid = 1'b0;
        bus.r_valid = 1'b1; bus.r_taken = rt; bus.r_target = rtgt;
        sb_q.push_back('{rt, pc, mis, rpc});
        stepCycle();
        bus.r_valid = 1'b0;
        n = 0;
        while (!bus.f_ready && n < 10) begin
            stepCycle();
            n++;
        end
        checkOutput("recover_len", n, mis ? 2 : 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bp_we) begin
                if (sb_q.size() == 0) begin
                    checkOutput("bp_we_unexpected", bus.bp_we, 0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    checkOutput("bp_taken", bus.bp_taken, mon_exp.taken);
                    checkOutput("bp_pc", bus.bp_pc, mon_exp.pc);
                    checkOutput("redirect_valid", bus.redirect_valid, mon_exp.mis);
                    if (mon_exp.mis) checkOutput("redirect_pc", bus.redirect_pc, mon_exp.rpc);
                end
            end else if (bus.redirect_valid) begin
                checkOutput("redirect_stray", bus.redirect_valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        vecs[0] = '{26'h10,       1'b1, 26'h40, 1'b1, 26'h40, 1'b0, 26'h0};
        vecs[1] = '{26'h20,       1'b0, 26'h0,  1'b1, 26'h80, 1'b1, 26'h80};
        vecs[2] = '{26'h30,       1'b1, 26'h50, 1'b0, 26'h0,  1'b1, 26'h31};
        vecs[3] = '{26'h44,       1'b0, 26'h0,  1'b0, 26'h99, 1'b0, 26'h0};
        vecs[4] = '{26'h55,       1'b1, 26'h60, 1'b1, 26'h61, 1'b1, 26'h61};
        vecs[5] = '{26'h3FFFFFF,  1'b1, 26'h5,  1'b0, 26'h0,  1'b1, 26'h0};
        vecs[6] = '{26'h70,       1'b1, 26'h71, 1'b1, 26'h71, 1'b0, 26'h0};

        bus.f_valid = 1'b0; bus.f_pc = '0; bus.f_pred_taken = 1'b0; bus.f_pred_target = '0;
        bus.r_valid = 1'b0; bus.r_taken = 1'b0; bus.r_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_f_ready", bus.f_ready, 1);
        checkOutput("rst_bp_we", bus.bp_we, 0);
        checkOutput("rst_bp_pc", bus.bp_pc, 0);
        checkOutput("rst_redirect_valid", bus.redirect_valid, 0);
        checkOutput("rst_redirect_pc", bus.redirect_pc, 0);
        checkOutput("rst_err", bus.err_underflow, 0);
        checkOutput("rst_stat_br", bus.stat_branches, 0);
        checkOutput("rst_stat_mis", bus.stat_mispredicts, 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].pt, vecs[i].ptgt, vecs[i].rt, vecs[i].rtgt,
                          vecs[i].mis, vecs[i].rpc);
        end
        checkOutput("table_stat_br", bus.stat_branches, 7);
        checkOutput("table_stat_mis", bus.stat_mispredicts, 4);

        // Mispredict with a second entry queued and a coincident push: both must vanish.
        bus.f_valid = 1'b1; bus.f_pc = 26'h30; bus.f_pred_taken = 1'b1; bus.f_pred_target = 26'h50;
        stepCycle();
        bus.f_pc = 26'h90; bus.f_pred_taken = 1'b0; bus.f_pred_target = 26'h0;
        stepCycle();
        bus.f_pc = 26'hEE;
        bus.r_valid = 1'b1; bus.r_taken = 1'b0; bus.r_target = 26'h0;
        sb_q.push_back('{1'b0, 26'h30, 1'b1, 26'h31});
        stepCycle();
        bus.f_valid = 1'b0; bus.r_valid = 1'b0;
        checkOutput("flush_f_ready_low", bus.f_ready, 0);
        repeat (2) stepCycle();
        applyStimulus(26'hA0, 1'b1, 26'hB0, 1'b1, 26'hB0, 1'b0, 26'h0);

        // Fill, refuse a push while full, then stream through the wrap point.
        for (int i = 0; i < 4; i++) begin
            bus.f_valid = 1'b1; bus.f_pc = 26'h100 + 26'(i);
            bus.f_pred_taken = 1'b0; bus.f_pred_target = '0;
            model_q.push_back(26'h100 + 26'(i));
            stepCycle();
        end
        bus.f_valid = 1'b0;
        checkOutput("full_f_ready", bus.f_ready, 0);
        bus.f_valid = 1'b1; bus.f_pc = 26'h1FF;
        bus.r_valid = 1'b1; bus.r_taken = 1'b0; bus.r_target = '0;
        sb_q.push_back('{1'b0, model_q.pop_front(), 1'b0, 26'h0});
        stepCycle();
        checkOutput("after_full_ready", bus.f_ready, 1);
        for (int i = 0; i < 10; i++) begin
            bus.f_pc = 26'h200 + 26'(i);
            sb_q.push_back('{1'b0, model_q.pop_front(), 1'b0, 26'h0});
            model_q.push_back(26'h200 + 26'(i));
            stepCycle();
        end
        bus.f_valid = 1'b0;
        while (model_q.size() > 0) begin
            sb_q.push_back('{1'b0, model_q.pop_front(), 1'b0, 26'h0});
            stepCycle();
        end
        bus.r_valid = 1'b0;
        stepCycle();
        checkOutput("wrap_stat_br_sat", bus.stat_branches, 4'hF);
        checkOutput("wrap_stat_mis", bus.stat_mispredicts, 5);

        // Resolve on an empty queue with a same-cycle push: no bypass, sticky error.
        bus.f_valid = 1'b1; bus.f_pc = 26'h300; bus.f_pred_taken = 1'b0; bus.f_pred_target = '0;
        bus.r_valid = 1'b1; bus.r_taken = 1'b1; bus.r_target = '0;
        stepCycle();
        bus.f_valid = 1'b0; bus.r_valid = 1'b0;
        checkOutput("underflow_err", bus.err_underflow, 1);
        checkOutput("underflow_bp_we", bus.bp_we, 0);
        repeat (3) stepCycle();
        checkOutput("underflow_sticky", bus.err_underflow, 1);
        bus.r_valid = 1'b1; bus.r_taken = 1'b0;
        sb_q.push_back('{1'b0, 26'h300, 1'b0, 26'h0});
        stepCycle();
        bus.r_valid = 1'b0;
        stepCycle();

        // Reset asserted while recovering.
        bus.f_valid = 1'b1; bus.f_pc = 26'h310; bus.f_pred_taken = 1'b0; bus.f_pred_target = '0;
        stepCycle();
        bus.f_valid = 1'b0;
        bus.r_valid = 1'b1; bus.r_taken = 1'b1; bus.r_target = 26'h77;
        stepCycle();
        bus.r_valid = 1'b0;
        checkOutput("pre_rst_redirect", bus.redirect_valid, 1);
        checkOutput("pre_rst_redirect_pc", bus.redirect_pc, 26'h77);
        checkOutput("pre_rst_f_ready", bus.f_ready, 0);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_f_ready", bus.f_ready, 1);
        checkOutput("mid_rst_bp_we", bus.bp_we, 0);
        checkOutput("mid_rst_redirect", bus.redirect_valid, 0);
        checkOutput("mid_rst_err", bus.err_underflow, 0);
        checkOutput("mid_rst_stat_br", bus.stat_branches, 0);
        checkOutput("mid_rst_stat_mis", bus.stat_mispredicts, 0);
        stepCycle();
        rst = 1'b0;
        stepCycle();

        // Saturation of both statistics counters.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(26'h400 + 26'(i), 1'b1, 26'h500, 1'b1, 26'h500, 1'b0, 26'h0);
            if (i == 9) checkOutput("sat_br_mid", bus.stat_branches, 10);
        end
        checkOutput("sat_br", bus.stat_branches, 4'hF);
        checkOutput("sat_mis_zero", bus.stat_mispredicts, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(26'h600 + 26'(i), 1'b0, 26'h0, 1'b1, 26'h700 + 26'(i),
                          1'b1, 26'h700 + 26'(i));
        end
        checkOutput("sat_mis", bus.stat_mispredicts, 4'hF);
        checkOutput("sat_br_hold", bus.stat_branches, 4'hF);

        repeat (2) stepCycle();
        checkOutput("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
